// File: rtl/maf_pipe_stage_pkg.sv
// Shared MAF datapath field widths and payload-width helper for the elastic pipe stage.
package maf_pipe_stage_pkg;

  localparam int unsigned MAF_P_W   = 74;
  localparam int unsigned MAF_SH_W  = 10;
  localparam int unsigned MAF_ESH_W = 2;
  localparam int unsigned MAF_REV_W = 2;
  localparam int unsigned MAF_CNT_W = 4;
  localparam int unsigned MAF_DEPTH = 1;

  // Payload is packed as {P, SH, ESH, REV}, most significant first.
  function automatic int unsigned maf_payload_w(input int unsigned p_w, input int unsigned sh_w,
                                                input int unsigned esh_w, input int unsigned rev_w);
    return p_w + sh_w + esh_w + rev_w;
  endfunction

endpackage

// File: rtl/maf_skid_slot.sv
// One elastic register stage: main register plus skid slot, registered ready, synchronous flush.
module maf_skid_slot
  #(parameter int unsigned W = 8)
  (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
  );

  logic         m_v_r;
  logic         s_v_r;
  logic [W-1:0] m_d_r;
  logic [W-1:0] s_d_r;
  logic         push_s;
  logic         pop_s;

  assign push_s    = in_valid && !s_v_r;
  assign pop_s     = m_v_r && out_ready;
  assign in_ready  = !s_v_r;
  assign out_valid = m_v_r;
  assign out_data  = m_d_r;

  // Valid flags; the skid is only ever occupied while main is occupied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_v_r <= 1'b0;
      s_v_r <= 1'b0;
    end else if (flush) begin
      m_v_r <= 1'b0;
      s_v_r <= 1'b0;
    end else if (!m_v_r) begin
      m_v_r <= push_s;
    end else if (pop_s) begin
      if (s_v_r) begin
        s_v_r <= 1'b0;
      end else begin
        m_v_r <= push_s;
      end
    end else if (push_s) begin
      s_v_r <= 1'b1;
    end
  end

  // Payload registers; a flush squashes the flags only, so data is simply left alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_d_r <= {W{1'b0}};
      s_d_r <= {W{1'b0}};
    end else if (!flush) begin
      if (!m_v_r || pop_s) begin
        if (s_v_r) begin
          m_d_r <= s_d_r;
        end else if (push_s) begin
          m_d_r <= in_data;
        end
      end else if (push_s) begin
        s_d_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/maf_pipe_stage.sv
// Parametrised elastic MAF pipeline: DEPTH chained skid stages carrying P/SH/ESH/REV, with occupancy count.
module maf_pipe_stage
  import maf_pipe_stage_pkg::*;
  #(
  parameter int unsigned P_W   = MAF_P_W,
  parameter int unsigned SH_W  = MAF_SH_W,
  parameter int unsigned ESH_W = MAF_ESH_W,
  parameter int unsigned REV_W = MAF_REV_W,
  parameter int unsigned DEPTH = MAF_DEPTH,
  parameter int unsigned CNT_W = MAF_CNT_W
  )
  (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_p,
  input  logic [SH_W-1:0]  in_sh,
  input  logic [ESH_W-1:0] in_esh,
  input  logic [REV_W-1:0] in_rev,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic [SH_W-1:0]  out_sh,
  output logic [ESH_W-1:0] out_esh,
  output logic [REV_W-1:0] out_rev,
  output logic [CNT_W-1:0] occ
  );

  localparam int unsigned PAYLOAD_W = maf_payload_w(P_W, SH_W, ESH_W, REV_W);

  logic                 v_s [0:DEPTH];
  logic                 r_s [0:DEPTH];
  logic [PAYLOAD_W-1:0] d_s [0:DEPTH];
  logic                 push_s;
  logic                 pop_s;
  logic [CNT_W-1:0]     occ_r;

  assign v_s[0]     = in_valid;
  assign d_s[0]     = {in_p, in_sh, in_esh, in_rev};
  assign r_s[DEPTH] = out_ready;
  assign in_ready   = r_s[0];
  assign out_valid  = v_s[DEPTH];
  assign {out_p, out_sh, out_esh, out_rev} = d_s[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    maf_skid_slot #(.W(PAYLOAD_W)) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (v_s[k]),
      .in_ready  (r_s[k]),
      .in_data   (d_s[k]),
      .out_valid (v_s[k+1]),
      .out_ready (r_s[k+1]),
      .out_data  (d_s[k+1])
    );
  end

  assign push_s = in_valid && r_s[0];
  assign pop_s  = v_s[DEPTH] && out_ready;
  assign occ    = occ_r;

  // Occupancy tracks accepted minus delivered entries; a flush empties the pipe outright.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      occ_r <= {CNT_W{1'b0}};
    end else if (push_s && !pop_s) begin
      occ_r <= occ_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!push_s && pop_s) begin
      occ_r <= occ_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
